// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle control sequencer for a 9-bit instruction set.
// Fetches one instruction at a time from an external ROM, decodes the opcode
// and drives the register file / ALU / data memory strobes cycle by cycle.
// One Start runs the program from PC 0 until the next PC equals PROG_LEN,
// then Done is held until Start is released.
//
// Ports:
//   Clk, Reset_n              clock (rising edge), async active-low reset
//   Start                     begin a program run (honoured in IDLE/DONE only)
//   Instr_req, Pc_out         instruction fetch request and address
//   Instr_in, Instr_valid     fetched word {op[8:6], ra[5:3], rb[2:0]} + valid
//   Ra_addr, Rb_addr, Alu_op  decoded IR fields, stable from DECODE onward
//   Ra_data                   register A contents (BGZ condition)
//   Alu_en, Reg_we            one-cycle ALU and register-write strobes
//   Mem_req, Mem_we, Mem_ack  data memory handshake (Mem_we=1 for STR)
//   Done                      program finished
module ctrl_sequencer #(
  parameter int PC_W     = 10,
  parameter int PROG_LEN = 1023
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Start,
  output logic            Instr_req,
  output logic [PC_W-1:0] Pc_out,
  input  logic [8:0]      Instr_in,
  input  logic            Instr_valid,
  output logic [2:0]      Ra_addr,
  output logic [2:0]      Rb_addr,
  input  logic [7:0]      Ra_data,
  output logic [2:0]      Alu_op,
  output logic            Alu_en,
  output logic            Reg_we,
  output logic            Mem_req,
  output logic            Mem_we,
  input  logic            Mem_ack,
  output logic            Done
);

  typedef enum logic [2:0] {
    stIdle, stFetch, stDecode, stExec, stMem, stWb, stDone
  } state_t;

  localparam logic [2:0]      OpLod   = 3'b011;
  localparam logic [2:0]      OpStr   = 3'b100;
  localparam logic [2:0]      OpBgz   = 3'b101;
  localparam logic [PC_W-1:0] ProgEnd = PC_W'(PROG_LEN);

  state_t          state, stateNext;
  logic [PC_W-1:0] pc, pcNext;
  logic [8:0]      ir, irNext;
  logic [2:0]      op;
  logic [PC_W-1:0] branchOff, branchPc, seqPc;
  logic            bgzCond;
  logic            retire;
  logic            takeBranch;

  assign op = ir[8:6];

  // Decoded fields come straight from IR, so they read 0 after reset and
  // stay stable from DECODE until the next instruction is latched.
  assign Pc_out  = pc;
  assign Ra_addr = ir[5:3];
  assign Rb_addr = ir[2:0];
  assign Alu_op  = op;

  // BGZ: Ra_data is a signed byte; rb is a signed 3-bit PC offset.
  assign bgzCond   = $signed(Ra_data) > 8'sd0;
  assign branchOff = PC_W'($signed(ir[2:0]));
  assign branchPc  = pc + branchOff;
  assign seqPc     = pc + PC_W'(1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= stIdle;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
      ir    <= irNext;
    end
  end

  always_comb begin
    stateNext  = state;
    pcNext     = pc;
    irNext     = ir;
    Instr_req  = 1'b0;
    Alu_en     = 1'b0;
    Reg_we     = 1'b0;
    Mem_req    = 1'b0;
    Mem_we     = 1'b0;
    Done       = 1'b0;
    retire     = 1'b0;
    takeBranch = 1'b0;

    case (state)
      stIdle: begin
        if (Start) begin
          stateNext = stFetch;
          pcNext    = '0;
        end
      end
      stFetch: begin
        Instr_req = 1'b1;
        if (Instr_valid) begin
          irNext    = Instr_in;
          stateNext = stDecode;
        end
      end
      stDecode: stateNext = stExec;
      stExec: begin
        Alu_en = 1'b1;
        case (op)
          OpLod, OpStr: stateNext = stMem;
          OpBgz: begin
            retire     = 1'b1;
            takeBranch = bgzCond;
          end
          default: stateNext = stWb;
        endcase
      end
      stMem: begin
        Mem_req = 1'b1;
        Mem_we  = (op == OpStr);
        if (Mem_ack) begin
          if (op == OpStr) retire = 1'b1;
          else             stateNext = stWb;
        end
      end
      stWb: begin
        Reg_we = 1'b1;
        retire = 1'b1;
      end
      stDone: begin
        Done = 1'b1;
        if (!Start) stateNext = stIdle;
      end
      default: stateNext = stIdle;
    endcase

    // End of an instruction: advance PC (modulo 2^PC_W) and decide whether
    // the program has reached its end address.
    if (retire) begin
      pcNext    = takeBranch ? branchPc : seqPc;
      stateNext = (pcNext == ProgEnd) ? stDone : stFetch;
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer. Random programs are interpreted at
// instruction level to produce the expected stream of observable events
// (fetch, ALU strobe, memory completion, write-back, done); a monitor pops
// and compares that stream as the DUT produces it.
module tb_ctrl_sequencer;
  localparam int PC_W       = 4;
  localparam int PROG_LEN   = 12;
  localparam int ROM_SZ     = 1 << PC_W;
  localparam int STEP_LIMIT = 25;
  localparam int RUNS       = 40;
  localparam int RUN_BUDGET = 1500;

  localparam int EV_FETCH = 0;
  localparam int EV_EXEC  = 1;
  localparam int EV_MEM   = 2;
  localparam int EV_WB    = 3;
  localparam int EV_DONE  = 4;

  typedef struct {
    int kind;
    int pc;
    int op;
    int ra;
    int rb;
    int we;
    int delta;
  } ev_t;

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b0;
  logic            Start = 1'b0;
  logic            Instr_req;
  logic [PC_W-1:0] Pc_out;
  logic [8:0]      Instr_in = '0;
  logic            Instr_valid = 1'b0;
  logic [2:0]      Ra_addr, Rb_addr, Alu_op;
  logic [7:0]      Ra_data;
  logic            Alu_en, Reg_we, Mem_req, Mem_we, Done;
  logic            Mem_ack = 1'b0;

  logic [8:0] rom  [ROM_SZ];
  logic [7:0] regs [8];
  ev_t        q[$];

  int checks = 0;
  int failures = 0;
  int runId = 0;
  int allowed = 0;
  int fetchesSeen = 0;
  int memWait = 0;

  ctrl_sequencer #(.PC_W(PC_W), .PROG_LEN(PROG_LEN)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
    .Instr_req(Instr_req), .Pc_out(Pc_out),
    .Instr_in(Instr_in), .Instr_valid(Instr_valid),
    .Ra_addr(Ra_addr), .Rb_addr(Rb_addr), .Ra_data(Ra_data),
    .Alu_op(Alu_op), .Alu_en(Alu_en), .Reg_we(Reg_we),
    .Mem_req(Mem_req), .Mem_we(Mem_we), .Mem_ack(Mem_ack),
    .Done(Done)
  );

  always #5 Clk = ~Clk;

  assign Ra_data = regs[Ra_addr];

  function automatic ev_t mkEv(int kind, int pc, int op, int ra, int rb, int we, int delta);
    ev_t e;
    e.kind = kind; e.pc = pc; e.op = op; e.ra = ra; e.rb = rb; e.we = we; e.delta = delta;
    return e;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, got, want, $time);
    end
  endtask

  task automatic observe(input ev_t a);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event kind=%0d pc=%0d op=%0d ra=%0d t=%0t", a.kind, a.pc, a.op, a.ra, $time);
      return;
    end
    e = q.pop_front();
    if (a.kind != e.kind || a.pc != e.pc || a.op != e.op || a.ra != e.ra ||
        a.rb != e.rb || a.we != e.we || (e.delta >= 0 && a.delta != e.delta)) begin
      failures++;
      $display("FAIL event got kind=%0d pc=%0d op=%0d ra=%0d rb=%0d we=%0d dt=%0d want kind=%0d pc=%0d op=%0d ra=%0d rb=%0d we=%0d dt=%0d t=%0t",
               a.kind, a.pc, a.op, a.ra, a.rb, a.we, a.delta,
               e.kind, e.pc, e.op, e.ra, e.rb, e.we, e.delta, $time);
    end
  endtask

  // Instruction-level reference: walk the program and list what should be
  // seen. Returns whether the program reaches PROG_LEN within STEP_LIMIT.
  task automatic buildRun(input bit directed, output bit expectDone);
    int pc, npc, n, op, ra, rb, off;
    for (int i = 0; i < ROM_SZ; i++) rom[i] = 9'($urandom);
    if (directed) begin
      rom[0] = 9'b000_001_010;
      rom[1] = 9'b011_011_100;
      rom[2] = 9'b100_011_100;
      rom[3] = 9'b101_010_110;
    end
    for (int r = 0; r < 8; r++) begin
      case ($urandom % 6)
        0: regs[r] = 8'h00;
        1: regs[r] = 8'h01;
        2: regs[r] = 8'h80;
        3: regs[r] = 8'h7f;
        4: regs[r] = 8'hff;
        default: regs[r] = 8'($urandom);
      endcase
    end
    pc = 0; n = 0; expectDone = 1'b0;
    while (n < STEP_LIMIT && !expectDone) begin
      op = int'(rom[pc][8:6]);
      ra = int'(rom[pc][5:3]);
      rb = int'(rom[pc][2:0]);
      q.push_back(mkEv(EV_FETCH, pc, 0, 0, 0, 0, -1));
      q.push_back(mkEv(EV_EXEC, 0, op, ra, rb, 0, 2));
      npc = pc + 1;
      if (op == 3 || op == 4) q.push_back(mkEv(EV_MEM, 0, op, ra, 0, (op == 4) ? 1 : 0, -1));
      if (op == 5) begin
        if (int'($signed(regs[ra])) > 0) begin
          off = (rb >= 4) ? rb - 8 : rb;
          npc = pc + off;
        end
      end else if (op != 4) begin
        q.push_back(mkEv(EV_WB, 0, op, ra, 0, 0, 1));
      end
      npc = ((npc % ROM_SZ) + ROM_SZ) % ROM_SZ;
      n++;
      if (npc == PROG_LEN) begin
        q.push_back(mkEv(EV_DONE, npc, 0, 0, 0, 0, 1));
        expectDone = 1'b1;
      end
      pc = npc;
    end
    allowed = n;
  endtask

  task automatic resetDut();
    Reset_n = 1'b0;
    #1;
    chk("rst_strobes", int'({Instr_req, Alu_en, Reg_we, Mem_req, Mem_we, Done}), 0);
    chk("rst_fields", int'({Ra_addr, Rb_addr, Alu_op}), 0);
    chk("rst_pc", int'(Pc_out), 0);
    q.delete();
    Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  // ROM model: answers fetches after a random wait, but only for as many
  // instructions as the reference walked.
  always @(negedge Clk) begin
    if (Instr_req) begin
      if (fetchesSeen < allowed) begin
        Instr_valid = ($urandom % 3) != 0;
        Instr_in    = rom[Pc_out];
      end else begin
        Instr_valid = 1'b0;
        Instr_in    = 9'($urandom);
      end
    end else begin
      Instr_valid = 1'($urandom);
      Instr_in    = 9'($urandom);
    end
  end

  // Data memory model: random 0..3 cycle ack delay; stray acks outside MEM.
  always @(negedge Clk) begin
    static bit memActive = 1'b0;
    static int memCnt = 0;
    if (Mem_req) begin
      if (!memActive) begin
        memActive = 1'b1;
        memWait   = $urandom_range(0, 3);
        memCnt    = 0;
      end
      Mem_ack = (memCnt == memWait);
      memCnt++;
    end else begin
      memActive = 1'b0;
      Mem_ack   = ($urandom % 4) == 0;
    end
  end

  // Monitor: samples mid low phase, turns DUT activity into events.
  initial begin
    int lastRun;
    int cyc;
    int lastEv;
    int memCycles;
    bit doneLast;
    lastRun = -1; cyc = 0; lastEv = 0; memCycles = 0; doneLast = 1'b0;
    forever begin
      @(negedge Clk);
      #3;
      if (runId != lastRun) begin
        lastRun = runId; fetchesSeen = 0; cyc = 0; lastEv = 0;
      end
      if (!Reset_n) begin
        doneLast = 1'b0; memCycles = 0;
      end else begin
        cyc++;
        chk("one_strobe", (int'(Reg_we) + int'(Alu_en) + int'(Mem_req)) <= 1 ? 1 : 0, 1);
        if (Mem_req) memCycles++;
        if (Instr_req && Instr_valid) begin
          fetchesSeen++;
          observe(mkEv(EV_FETCH, int'(Pc_out), 0, 0, 0, 0, cyc - lastEv));
          lastEv = cyc;
        end
        if (Alu_en) begin
          observe(mkEv(EV_EXEC, 0, int'(Alu_op), int'(Ra_addr), int'(Rb_addr), 0, cyc - lastEv));
          lastEv = cyc;
        end
        if (Mem_req && Mem_ack) begin
          chk("mem_req_len", memCycles, memWait + 1);
          observe(mkEv(EV_MEM, 0, int'(Alu_op), int'(Ra_addr), 0, int'(Mem_we), cyc - lastEv));
          lastEv = cyc;
        end
        if (Reg_we) begin
          observe(mkEv(EV_WB, 0, int'(Alu_op), int'(Ra_addr), 0, 0, cyc - lastEv));
          lastEv = cyc;
        end
        if (Done && !doneLast) begin
          observe(mkEv(EV_DONE, int'(Pc_out), 0, 0, 0, 0, cyc - lastEv));
          lastEv = cyc;
        end
        if (!Mem_req) memCycles = 0;
        doneLast = Done;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    @(negedge Clk);
    resetDut();
    for (int run = 0; run < RUNS; run++) begin
      bit expectDone;
      bit abortRun;
      bit finished;
      int abortAt;
      runId++;
      q.delete();
      buildRun(run == 0, expectDone);
      abortRun = (run % 5) == 4;
      abortAt  = $urandom_range(3, 60);
      finished = 1'b0;
      Start = 1'b1;
      @(negedge Clk);
      for (int c = 0; c < RUN_BUDGET; c++) begin
        // Start toggles freely mid-program (must be ignored); it is held
        // high as the run nears its end so DONE is entered with Start=1.
        Start = (q.size() >= 3) ? 1'($urandom) : 1'b1;
        if (abortRun && (Mem_req || c == abortAt)) begin
          finished = 1'b1;
          break;
        end
        if (q.size() == 0 && (expectDone ? Done : Instr_req)) begin
          finished = 1'b1;
          break;
        end
        @(negedge Clk);
      end
      if (!finished) begin
        checks++;
        failures++;
        $display("FAIL run_timeout run=%0d pending_events=%0d want=0", run, q.size());
        resetDut();
      end else if (abortRun || !expectDone) begin
        resetDut();
      end else begin
        Start = 1'b1;
        repeat (3) begin
          @(negedge Clk);
          #1;
          chk("done_hold", int'(Done), 1);
          chk("done_no_fetch", int'(Instr_req), 0);
          chk("done_pc_frozen", int'(Pc_out), PROG_LEN);
        end
        Start = 1'b0;
        @(negedge Clk);
        #1;
        chk("done_release", int'(Done), 0);
        chk("idle_no_fetch", int'(Instr_req), 0);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
